spi_xfer_sched: RTL and testbench
=================================

Name: spi_xfer_sched

Overview:
- Two-requester scheduler for the shared byte-wide SPI master core, driven through that core's 8-bit Wishbone slave port.
- Arbitrates byte transfers and bursts round-robin, and runs the register sequence for each burst: slave-select, data write, completion wait, data read, flag clear, deselect.
- Returns each received byte to the granted requester.
- Sits between the ibex-side peripheral clients and the SPI core.

Parameters:
ADR_STATUS, 3'd1, SPI status register address; write with bit 7 set clears completion flag
ADR_DATA, 3'd2, SPI data register address (TX on write, RX on read)
ADR_SS, 3'd4, slave-select register address
CS_MASK, 8'h01, value written to ADR_SS to assert chip select
TIMEOUT, 1024, max cycles waiting for spi_irq_i per byte (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  2  per-requester byte request
req_data_i  in  16  TX byte; [7:0] requester 0, [15:8] requester 1
req_last_i  in  2  byte is last of burst; CS released after it
req_ready_o  out  2  one-cycle pulse: request byte captured
rsp_valid_o  out  2  one-cycle pulse: response for that requester
rsp_data_o  out  8  RX byte, valid with rsp_valid_o
rsp_err_o  out  1  timeout flag, valid with rsp_valid_o
busy_o  out  1  burst in progress
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_adr_o  out  3  register address
wb_we_o  out  1  write enable
wb_dat_o  out  8  write data
wb_dat_i  in  8  read data
wb_ack_i  in  1  Wishbone acknowledge
spi_irq_i  in  1  SPI core transfer-complete interrupt

Behaviour:
- Reset: every output 0; state IDLE; round-robin pointer = requester 0; grant cleared.
- Wishbone:
  - One access at a time; cyc/stb/adr/we/dat_o held stable until wb_ack_i; deasserted the cycle after ack.
  - Read data sampled on the ack cycle.
  - No access ever issued in IDLE, HOLD or WAIT_IRQ.
- FSM:
  - IDLE: grant to the valid requester. If both are valid, the pointer wins. Go to SEL.
  - SEL: write CS_MASK to ADR_SS. On ack, go to TXW.
  - TXW: capture granted req_data and req_last on entry. Pulse req_ready_o[g] in the same cycle. Write the byte to ADR_DATA. On ack, clear timer and go to WAIT_IRQ.
  - WAIT_IRQ: spi_irq_i=1 goes to RXR. Timer reaching TIMEOUT goes to ERR.
  - RXR: read ADR_DATA, capture wb_dat_i. On ack, go to CLR.
  - CLR: write 8'h80 to ADR_STATUS. On ack, pulse rsp_valid_o[g] with the captured byte and rsp_err_o=0. If last, go to DESEL; else go to HOLD.
  - HOLD: CS stays asserted. req_valid_i[g]=1 goes to TXW. Other requester is ignored; no timeout.
  - ERR: pulse rsp_valid_o[g] with rsp_err_o=1 and rsp_data_o=0. Go to DESEL; the burst is aborted.
  - DESEL: write 8'h00 to ADR_SS. On ack, flip pointer to the other requester, clear grant, go to IDLE.
- busy_o = 1 in every state except IDLE.
- Latency: with zero-wait ack and immediate irq, first byte to rsp_valid ≤ 12 cycles.
- Pointer flips only at burst end, so one requester cannot starve the other between bursts.
- Same-cycle irq and timeout terminal count: irq wins.
- spi_irq_i outside WAIT_IRQ is ignored.
- Requester dropping req_valid after grant but before TXW capture: stays in HOLD.
- Async reset mid-access drops wb_cyc_o immediately. The SPI core is not deselected; it is reset by the system alongside.

Test Plan:
- Single byte: req0 valid, data 8'hA5, last=1.
  - Wishbone writes, in order: SS=01, DATA=A5, (irq), read DATA returns 3C, STATUS=80, SS=00.
  - Response: rsp_valid_o=01, rsp_data_o=3C, rsp_err_o=0; pointer then = 1.
- Contention: both requesters valid from reset, single bytes 11 and 22, last=1.
  - Requester 0 served first, then requester 1.
  - Exactly two SS=01/SS=00 pairs.
- Burst of 3 (last on byte 3) from requester 1 while requester 0 is valid throughout.
  - SS written once at start and once at end.
  - Requester 0 granted only after DESEL ack.
- Timeout: irq never asserted, TIMEOUT=16.
  - rsp_valid with rsp_err_o=1, data 00, SS=00 written; no RXR or CLR accesses.
- Wait states: wb_ack_i delayed 5 cycles on every access.
  - Outputs stable until ack; no back-to-back stb without a deassert cycle.
  - Results identical to the single-byte case.
- Reset asserted during WAIT_IRQ: all outputs 0 asynchronously. After release a new request proceeds normally from SEL.

Source files
------------

// File: rtl/spi_xfer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_xfer_sched
// Brief    : Round-robin two-requester byte/burst scheduler that sequences the
//            SPI master core's Wishbone registers (select, TX, wait, RX, clear,
//            deselect) and returns each RX byte to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_sched #(
    parameter logic [2:0] ADR_STATUS = 3'd1,
    parameter logic [2:0] ADR_DATA   = 3'd2,
    parameter logic [2:0] ADR_SS     = 3'd4,
    parameter logic [7:0] CS_MASK    = 8'h01,
    parameter int         TIMEOUT    = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    input  logic [1:0]  req_last_i,
    output logic [1:0]  req_ready_o,
    output logic [1:0]  rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_adr_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        spi_irq_i
);

    localparam int c_TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SEL      = 4'd1,
        S_TXW      = 4'd2,
        S_WAIT_IRQ = 4'd3,
        S_RXR      = 4'd4,
        S_CLR      = 4'd5,
        S_HOLD     = 4'd6,
        S_ERR      = 4'd7,
        S_DESEL    = 4'd8
    } state_t;

    state_t                 r_state;
    logic                   r_ptr;
    logic                   r_gnt;
    logic                   r_last;
    logic [7:0]             r_rx;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [7:0]             w_tx_byte;
    logic                   w_wb_idle;
    logic                   w_wb_done;

    assign w_tx_byte = r_gnt ? req_data_i[15:8] : req_data_i[7:0];
    // A state launches its access when the bus is idle and advances on ack;
    // the drop on ack guarantees one idle cycle between consecutive strobes.
    assign w_wb_idle = ~wb_cyc_o;
    assign w_wb_done = wb_cyc_o & wb_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b0;
            r_rx        <= 8'h00;
            r_timer     <= '0;
            req_ready_o <= 2'b00;
            rsp_valid_o <= 2'b00;
            rsp_data_o  <= 8'h00;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_adr_o    <= 3'd0;
            wb_we_o     <= 1'b0;
            wb_dat_o    <= 8'h00;
        end else begin
            req_ready_o <= 2'b00;
            rsp_valid_o <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        r_gnt   <= req_valid_i[r_ptr] ? r_ptr : ~r_ptr;
                        busy_o  <= 1'b1;
                        r_state <= S_SEL;
                    end
                end

                S_SEL: begin
                    if (w_wb_idle) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= ADR_SS;
                        wb_we_o  <= 1'b1;
                        wb_dat_o <= CS_MASK;
                    end else if (w_wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= 3'd0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 8'h00;
                        r_state  <= S_TXW;
                    end
                end

                S_TXW: begin
                    if (w_wb_idle) begin
                        // A requester that withdrew after the grant is parked in HOLD.
                        if (req_valid_i[r_gnt]) begin
                            req_ready_o[r_gnt] <= 1'b1;
                            r_last   <= req_last_i[r_gnt];
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_adr_o <= ADR_DATA;
                            wb_we_o  <= 1'b1;
                            wb_dat_o <= w_tx_byte;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (w_wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= 3'd0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 8'h00;
                        r_timer  <= '0;
                        r_state  <= S_WAIT_IRQ;
                    end
                end

                S_WAIT_IRQ: begin
                    if (spi_irq_i) begin
                        r_state <= S_RXR;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state <= S_ERR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_RXR: begin
                    if (w_wb_idle) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= ADR_DATA;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 8'h00;
                    end else if (w_wb_done) begin
                        r_rx     <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= 3'd0;
                        r_state  <= S_CLR;
                    end
                end

                S_CLR: begin
                    if (w_wb_idle) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= ADR_STATUS;
                        wb_we_o  <= 1'b1;
                        wb_dat_o <= 8'h80;
                    end else if (w_wb_done) begin
                        wb_cyc_o           <= 1'b0;
                        wb_stb_o           <= 1'b0;
                        wb_adr_o           <= 3'd0;
                        wb_we_o            <= 1'b0;
                        wb_dat_o           <= 8'h00;
                        rsp_valid_o[r_gnt] <= 1'b1;
                        rsp_data_o         <= r_rx;
                        rsp_err_o          <= 1'b0;
                        r_state            <= r_last ? S_DESEL : S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (req_valid_i[r_gnt]) begin
                        r_state <= S_TXW;
                    end
                end

                S_ERR: begin
                    rsp_valid_o[r_gnt] <= 1'b1;
                    rsp_data_o         <= 8'h00;
                    rsp_err_o          <= 1'b1;
                    r_state            <= S_DESEL;
                end

                S_DESEL: begin
                    if (w_wb_idle) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= ADR_SS;
                        wb_we_o  <= 1'b1;
                        wb_dat_o <= 8'h00;
                    end else if (w_wb_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= 3'd0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 8'h00;
                        r_ptr    <= ~r_ptr;
                        r_gnt    <= 1'b0;
                        busy_o   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_sched
// Brief    : Directed bench for spi_xfer_sched with a Wishbone slave model,
//            requester byte queues and an access/response log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sched;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_last, req_ready, rsp_valid;
    logic [15:0] req_data;
    logic [7:0]  rsp_data, wb_dat_o, wb_dat_i;
    logic        rsp_err, busy, cyc, stb, we, ack;
    logic        irq = 1'b0;
    logic [2:0]  adr;

    always #5 clk = ~clk;

    spi_xfer_sched #(.TIMEOUT(c_TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_adr_o(adr), .wb_we_o(we),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(ack),
        .spi_irq_i(irq)
    );

    // Requester byte queues: the main process appends, the monitor consumes.
    logic [7:0] q_data [2][32];
    logic       q_last [2][32];
    int         q_cnt  [2] = '{0, 0};
    int         q_idx  [2] = '{0, 0};

    always_comb begin
        req_valid[0]   = q_idx[0] < q_cnt[0];
        req_valid[1]   = q_idx[1] < q_cnt[1];
        req_data[7:0]  = q_data[0][q_idx[0] % 32];
        req_data[15:8] = q_data[1][q_idx[1] % 32];
        req_last[0]    = q_last[0][q_idx[0] % 32];
        req_last[1]    = q_last[1][q_idx[1] % 32];
    end

    // Wishbone slave: ack after wait_n stalled cycles, combinational on stb.
    int         wait_n = 0;
    int         wcnt = 0;
    logic [7:0] rd_byte = 8'h3C;
    logic       irq_en = 1'b1;
    assign ack      = cyc & stb & (wcnt == wait_n);
    assign wb_dat_i = rd_byte;
    always @(posedge clk) begin
        if (ack || !stb) wcnt <= 0;
        else             wcnt <= wcnt + 1;
    end

    typedef struct packed { logic w; logic [2:0] a; logic [7:0] d; } acc_t;
    typedef struct packed { logic [1:0] v; logic [7:0] d; logic e; } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   rsp_cyc[$];
    int   cyc_n = 0;
    int   data_ack_cyc = 0;
    int   pv = 0;
    logic p_stb = 1'b0, p_ack = 1'b0;
    acc_t p_acc = '0;
    int   irq_hold = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_stb = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (p_stb && !p_ack && (!stb || !cyc || {we, adr, wb_dat_o} != p_acc)) pv++;
            if (p_ack && stb) pv++;
            p_stb = stb;
            p_ack = ack;
            p_acc = {we, adr, wb_dat_o};
        end
        if (cyc && stb && ack) begin
            acc_q.push_back({we, adr, we ? wb_dat_o : wb_dat_i});
            if (we && adr == 3'd2) data_ack_cyc = cyc_n;
        end
        if (rsp_valid != 2'b00) begin
            rsp_q.push_back({rsp_valid, rsp_data, rsp_err});
            rsp_cyc.push_back(cyc_n);
        end
        if (req_ready[0]) q_idx[0]++;
        if (req_ready[1]) q_idx[1]++;
        if (irq_hold > 0) begin
            irq_hold--;
            if (irq_hold == 0) irq = 1'b0;
        end
        // irq rises before WAIT_IRQ is entered and stays up for it.
        if (irq_en && cyc && stb && ack && we && adr == 3'd2) begin
            irq = 1'b1;
            irq_hold = 2;
        end
    end

    int   checks = 0;
    int   errors = 0;
    acc_t exp_q[$];
    int   a_base = 0, r_base = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        q_data[r][q_cnt[r] % 32] = d;
        q_last[r][q_cnt[r] % 32] = l;
        q_cnt[r]++;
    endtask

    function automatic void e(input logic w, input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({w, a, d});
    endfunction

    function automatic void e_byte(input logic [7:0] tx, input logic [7:0] rx);
        e(1'b1, 3'd2, tx);
        e(1'b0, 3'd2, rx);
        e(1'b1, 3'd1, 8'h80);
    endfunction

    task automatic mark();
        a_base = acc_q.size();
        r_base = rsp_q.size();
        exp_q.delete();
    endtask

    task automatic cmp_log(input string nm);
        check({nm, "_nacc"}, acc_q.size() - a_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (a_base + i < acc_q.size())
                check($sformatf("%s_acc%0d", nm, i), acc_q[a_base + i], exp_q[i]);
    endtask

    task automatic cmp_rsp(input string nm, input int idx, input logic [1:0] v,
                           input logic [7:0] d, input logic er);
        if (r_base + idx < rsp_q.size()) check(nm, rsp_q[r_base + idx], {v, d, er});
        else                             check({nm, "_missing"}, 0, 1);
    endtask

    task automatic wait_idle(input string nm, input int nrsp, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((rsp_q.size() < r_base + nrsp || busy || cyc) && k < budget);
        check({nm, "_done"}, k < budget, 1);
        check({nm, "_nrsp"}, rsp_q.size() - r_base, nrsp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int         req;
        logic [7:0] tx;
        logic [7:0] rx;
        int         wt;
        logic [1:0] exp_v;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vt [5];

    initial begin
        int k;
        int t0;
        vt[0] = '{0, 8'hA5, 8'h3C, 0, 2'b01, 8'h3C};
        vt[1] = '{1, 8'h5A, 8'hC3, 0, 2'b10, 8'hC3};
        vt[2] = '{0, 8'hA5, 8'h3C, 5, 2'b01, 8'h3C};
        vt[3] = '{1, 8'hFF, 8'h00, 2, 2'b10, 8'h00};
        vt[4] = '{1, 8'h00, 8'hFF, 0, 2'b10, 8'hFF};

        repeat (3) @(negedge clk);
        check("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy,
                             cyc, stb, adr, we, wb_dat_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            wait_n  = vt[i].wt;
            rd_byte = vt[i].rx;
            mark();
            e(1'b1, 3'd4, 8'h01);
            e_byte(vt[i].tx, vt[i].rx);
            e(1'b1, 3'd4, 8'h00);
            push(vt[i].req, vt[i].tx, 1'b1);
            wait_idle($sformatf("vec%0d", i), 1, 400);
            cmp_log($sformatf("vec%0d", i));
            cmp_rsp($sformatf("vec%0d_rsp", i), 0, vt[i].exp_v, vt[i].exp_d, 1'b0);
        end
        check("wb_protocol", pv, 0);
        wait_n  = 0;
        rd_byte = 8'h3C;

        // Pointer moves to requester 1 after a requester-0 burst.
        do_reset();
        mark();
        push(0, 8'h11, 1'b1);
        wait_idle("ptr_a", 1, 200);
        mark();
        push(0, 8'hAA, 1'b1);
        push(1, 8'hBB, 1'b1);
        wait_idle("ptr_b", 2, 400);
        cmp_rsp("ptr_first", 0, 2'b10, 8'h3C, 1'b0);
        cmp_rsp("ptr_second", 1, 2'b01, 8'h3C, 1'b0);

        // Contention from reset: requester 0 first.
        do_reset();
        mark();
        rd_byte = 8'h77;
        e(1'b1, 3'd4, 8'h01); e_byte(8'h11, 8'h77); e(1'b1, 3'd4, 8'h00);
        e(1'b1, 3'd4, 8'h01); e_byte(8'h22, 8'h77); e(1'b1, 3'd4, 8'h00);
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        wait_idle("cont", 2, 400);
        cmp_log("cont");
        cmp_rsp("cont_r0", 0, 2'b01, 8'h77, 1'b0);
        cmp_rsp("cont_r1", 1, 2'b10, 8'h77, 1'b0);

        // Three-byte burst from requester 1, requester 0 waiting throughout.
        do_reset();
        mark();
        rd_byte = 8'h5E;
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b0);
        push(1, 8'hB3, 1'b1);
        @(negedge clk);
        push(0, 8'hC0, 1'b1);
        e(1'b1, 3'd4, 8'h01);
        e_byte(8'hB1, 8'h5E); e_byte(8'hB2, 8'h5E); e_byte(8'hB3, 8'h5E);
        e(1'b1, 3'd4, 8'h00);
        e(1'b1, 3'd4, 8'h01); e_byte(8'hC0, 8'h5E); e(1'b1, 3'd4, 8'h00);
        wait_idle("burst", 4, 800);
        cmp_log("burst");
        cmp_rsp("burst_b1", 0, 2'b10, 8'h5E, 1'b0);
        cmp_rsp("burst_b3", 2, 2'b10, 8'h5E, 1'b0);
        cmp_rsp("burst_r0", 3, 2'b01, 8'h5E, 1'b0);

        // Requester goes quiet mid-burst: CS held, no timeout in HOLD.
        mark();
        push(0, 8'hD1, 1'b0);
        k = 0;
        while (rsp_q.size() < r_base + 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("hold_first_done", k < 200, 1);
        repeat (30) @(negedge clk);
        check("hold_busy", busy, 1);
        check("hold_nacc", acc_q.size() - a_base, 4);
        check("hold_nrsp", rsp_q.size() - r_base, 1);
        push(0, 8'hD2, 1'b1);
        e(1'b1, 3'd4, 8'h01); e_byte(8'hD1, 8'h5E); e_byte(8'hD2, 8'h5E);
        e(1'b1, 3'd4, 8'h00);
        wait_idle("hold", 2, 400);
        cmp_log("hold");
        cmp_rsp("hold_rsp2", 1, 2'b01, 8'h5E, 1'b0);

        // Timeout: no irq; error response, straight to deselect.
        mark();
        irq_en = 1'b0;
        e(1'b1, 3'd4, 8'h01); e(1'b1, 3'd2, 8'hE7); e(1'b1, 3'd4, 8'h00);
        push(1, 8'hE7, 1'b1);
        wait_idle("tmo", 1, 400);
        cmp_log("tmo");
        cmp_rsp("tmo_rsp", 0, 2'b10, 8'h00, 1'b1);
        if (rsp_cyc.size() > r_base)
            check("tmo_delay", rsp_cyc[r_base] - data_ack_cyc, c_TO + 2);

        // Asynchronous reset while waiting for irq.
        mark();
        push(0, 8'hF0, 1'b1);
        k = 0;
        while (acc_q.size() < a_base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_wait", k < 200, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy,
                                    cyc, stb, adr, we, wb_dat_o}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        irq_en = 1'b1;
        @(negedge clk);
        mark();
        rd_byte = 8'h3C;
        e(1'b1, 3'd4, 8'h01); e_byte(8'h0F, 8'h3C); e(1'b1, 3'd4, 8'h00);
        t0 = cyc_n;
        push(0, 8'h0F, 1'b1);
        wait_idle("post_rst", 1, 400);
        cmp_log("post_rst");
        cmp_rsp("post_rst_rsp", 0, 2'b01, 8'h3C, 1'b0);
        if (rsp_cyc.size() > r_base)
            check("latency_le12", (rsp_cyc[r_base] - t0) <= 12, 1);
        check("wb_protocol_end", pv, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
